// File: rtl/datapath_memory_pkg.sv
// Shared definitions for the datapath memory write arbiter: scrub FSM
// state encoding and bank select constants.
package datapath_memory_pkg;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCRUB = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/datapath_memory_write_arbiter_write_port_mux.sv
// One memory write port: priority select ALU > scrub > host, then a
// registered address/data pair that drives the memory directly.
module write_port_mux #(
  parameter int WORD_WIDTH       = 36,
  parameter int WRITE_ADDR_WIDTH = 12,
  parameter int MEM_ADDR_WIDTH   = 10,
  parameter int NULL_WRITE_ADDR  = 4095
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        alu_wren,
  input  logic [WRITE_ADDR_WIDTH-1:0] alu_addr,
  input  logic [WORD_WIDTH-1:0]       alu_data,
  input  logic                        scrub_wren,
  input  logic [MEM_ADDR_WIDTH-1:0]   scrub_addr,
  input  logic                        host_wren,
  input  logic [MEM_ADDR_WIDTH-1:0]   host_addr,
  input  logic [WORD_WIDTH-1:0]       host_data,
  input  logic [WRITE_ADDR_WIDTH-1:0] base_addr,
  output logic [WRITE_ADDR_WIDTH-1:0] write_addr,
  output logic [WORD_WIDTH-1:0]       write_data
);

  localparam logic [WRITE_ADDR_WIDTH-1:0] NULL_ADDR = WRITE_ADDR_WIDTH'(NULL_WRITE_ADDR);

  logic [WRITE_ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [WORD_WIDTH-1:0]       write_data_q, write_data_d;

  // Local addresses become full write addresses by adding the bank base.
  always_comb begin
    write_addr_d = NULL_ADDR;
    write_data_d = '0;
    if (alu_wren) begin
      write_addr_d = alu_addr;
      write_data_d = alu_data;
    end else if (scrub_wren) begin
      write_addr_d = WRITE_ADDR_WIDTH'(scrub_addr) + base_addr;
      write_data_d = '0;
    end else if (host_wren) begin
      write_addr_d = WRITE_ADDR_WIDTH'(host_addr) + base_addr;
      write_data_d = host_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      write_addr_q <= NULL_ADDR;
      write_data_q <= '0;
    end else begin
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign write_addr = write_addr_q;
  assign write_data = write_data_q;

endmodule

// File: rtl/datapath_memory_write_arbiter.sv
// Shares the memory A/B write ports between the ALU (always first) and the
// host load port / scrub engine, which only use cycles the ALU leaves free.
module datapath_memory_write_arbiter
  import datapath_memory_pkg::*;
#(
  parameter int WORD_WIDTH            = 36,
  parameter int WRITE_ADDR_WIDTH      = 12,
  parameter int MEM_ADDR_WIDTH        = 10,
  parameter int MEM_DEPTH             = 1024,
  parameter int MEM_WRITE_BASE_ADDR_B = 1024,
  parameter int NULL_WRITE_ADDR       = 4095
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        alu_wren_A,
  input  logic                        alu_wren_B,
  input  logic [WRITE_ADDR_WIDTH-1:0] alu_write_addr_A,
  input  logic [WRITE_ADDR_WIDTH-1:0] alu_write_addr_B,
  input  logic [WORD_WIDTH-1:0]       alu_write_data_A,
  input  logic [WORD_WIDTH-1:0]       alu_write_data_B,
  input  logic                        host_valid,
  output logic                        host_ready,
  input  logic                        host_bank,
  input  logic [MEM_ADDR_WIDTH-1:0]   host_addr,
  input  logic [WORD_WIDTH-1:0]       host_data,
  input  logic                        scrub_start,
  output logic                        scrub_busy,
  output logic                        scrub_done,
  output logic [WRITE_ADDR_WIDTH-1:0] write_addr_A,
  output logic [WRITE_ADDR_WIDTH-1:0] write_addr_B,
  output logic [WORD_WIDTH-1:0]       write_data_A,
  output logic [WORD_WIDTH-1:0]       write_data_B,
  output state_e                      dbg_state
);

  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = MEM_ADDR_WIDTH'(MEM_DEPTH - 1);

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                      pend_q, pend_d;
  logic                      pend_bank_q, pend_bank_d;
  logic [MEM_ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [WORD_WIDTH-1:0]     pend_data_q, pend_data_d;

  logic handshake, scrub_fire, host_fire_a, host_fire_b;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_bank_q <= BANK_A;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_bank_q <= pend_bank_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  // Valid/ready: a host word is taken on the cycle host_valid && host_ready;
  // ready is low while a word is pending, while scrubbing, and during reset.
  always_comb begin
    host_ready  = reset_n && !pend_q && (state_q == IDLE);
    handshake   = host_valid && host_ready;
    scrub_fire  = (state_q == SCRUB) && !alu_wren_A && !alu_wren_B;
    host_fire_a = pend_q && (pend_bank_q == BANK_A) && !alu_wren_A && !scrub_fire;
    host_fire_b = pend_q && (pend_bank_q == BANK_B) && !alu_wren_B && !scrub_fire;
    scrub_busy  = (state_q != IDLE);
    scrub_done  = (state_q == DONE);
    dbg_state   = state_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_bank_d = pend_bank_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    case (state_q)
      // A same-cycle host handshake wins over scrub_start.
      IDLE: if (scrub_start && !pend_q && !handshake) begin
        state_d = SCRUB;
        cnt_d   = '0;
      end
      SCRUB: if (scrub_fire) begin
        if (cnt_q == LAST_ADDR) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + MEM_ADDR_WIDTH'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (host_fire_a || host_fire_b) pend_d = 1'b0;
    if (handshake) begin
      pend_d      = 1'b1;
      pend_bank_d = host_bank;
      pend_addr_d = host_addr;
      pend_data_d = host_data;
    end
  end

  write_port_mux #(
    .WORD_WIDTH(WORD_WIDTH), .WRITE_ADDR_WIDTH(WRITE_ADDR_WIDTH),
    .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH), .NULL_WRITE_ADDR(NULL_WRITE_ADDR)
  ) u_port_a (
    .clock(clock), .reset_n(reset_n),
    .alu_wren(alu_wren_A), .alu_addr(alu_write_addr_A), .alu_data(alu_write_data_A),
    .scrub_wren(scrub_fire), .scrub_addr(cnt_q),
    .host_wren(host_fire_a), .host_addr(pend_addr_q), .host_data(pend_data_q),
    .base_addr('0),
    .write_addr(write_addr_A), .write_data(write_data_A)
  );

  write_port_mux #(
    .WORD_WIDTH(WORD_WIDTH), .WRITE_ADDR_WIDTH(WRITE_ADDR_WIDTH),
    .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH), .NULL_WRITE_ADDR(NULL_WRITE_ADDR)
  ) u_port_b (
    .clock(clock), .reset_n(reset_n),
    .alu_wren(alu_wren_B), .alu_addr(alu_write_addr_B), .alu_data(alu_write_data_B),
    .scrub_wren(scrub_fire), .scrub_addr(cnt_q),
    .host_wren(host_fire_b), .host_addr(pend_addr_q), .host_data(pend_data_q),
    .base_addr(WRITE_ADDR_WIDTH'(MEM_WRITE_BASE_ADDR_B)),
    .write_addr(write_addr_B), .write_data(write_data_B)
  );

endmodule

// File: tb/tb_datapath_memory_write_arbiter.sv
// Bench for datapath_memory_write_arbiter: directed scenarios followed by a
// random phase, all checked against a transaction-level reference model.
module tb_datapath_memory_write_arbiter;
  import datapath_memory_pkg::*;

  localparam int WW = 36, AW = 12, MW = 10, DEPTH = 8, BASE_B = 1024, NULL_A = 4095;

  logic clock, reset_n;
  logic alu_wren_A, alu_wren_B;
  logic [AW-1:0] alu_write_addr_A, alu_write_addr_B;
  logic [WW-1:0] alu_write_data_A, alu_write_data_B;
  logic host_valid, host_ready, host_bank;
  logic [MW-1:0] host_addr;
  logic [WW-1:0] host_data;
  logic scrub_start, scrub_busy, scrub_done;
  logic [AW-1:0] write_addr_A, write_addr_B;
  logic [WW-1:0] write_data_A, write_data_B;
  state_e dbg_state;

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  datapath_memory_write_arbiter #(.MEM_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_wren_A(alu_wren_A), .alu_wren_B(alu_wren_B),
    .alu_write_addr_A(alu_write_addr_A), .alu_write_addr_B(alu_write_addr_B),
    .alu_write_data_A(alu_write_data_A), .alu_write_data_B(alu_write_data_B),
    .host_valid(host_valid), .host_ready(host_ready), .host_bank(host_bank),
    .host_addr(host_addr), .host_data(host_data),
    .scrub_start(scrub_start), .scrub_busy(scrub_busy), .scrub_done(scrub_done),
    .write_addr_A(write_addr_A), .write_addr_B(write_addr_B),
    .write_data_A(write_data_A), .write_data_B(write_data_B),
    .dbg_state(dbg_state)
  );

  // reference model: pending host words as a queue, scrub as an index
  typedef struct {
    logic          bank;
    logic [MW-1:0] addr;
    logic [WW-1:0] data;
  } host_req_t;

  host_req_t m_pend[$];
  bit        m_scrub_on, m_done;
  int        m_idx;
  logic [AW-1:0] e_addr_a, e_addr_b;
  logic [WW-1:0] e_data_a, e_data_b;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pend.delete();
    m_scrub_on = 1'b0;
    m_done     = 1'b0;
    m_idx      = 0;
    e_addr_a = AW'(NULL_A); e_addr_b = AW'(NULL_A);
    e_data_a = '0;          e_data_b = '0;
  endtask

  // driver: one clock cycle with the currently driven inputs
  task automatic step();
    bit exp_ready, idle_before, pend_before, hs, scrub_w, done_next;
    host_req_t r;
    state_e exp_state;
    #1;
    exp_ready = (reset_n === 1'b1) && (m_pend.size() == 0) && !m_scrub_on && !m_done;
    check("host_ready", 64'(host_ready), 64'(exp_ready));
    if (reset_n !== 1'b1) begin
      model_reset();
    end else begin
      idle_before = !m_scrub_on && !m_done;
      pend_before = (m_pend.size() != 0);
      hs = host_valid && exp_ready;
      done_next = 1'b0;
      e_addr_a = AW'(NULL_A); e_addr_b = AW'(NULL_A);
      e_data_a = '0;          e_data_b = '0;
      if (alu_wren_A) begin e_addr_a = alu_write_addr_A; e_data_a = alu_write_data_A; end
      if (alu_wren_B) begin e_addr_b = alu_write_addr_B; e_data_b = alu_write_data_B; end
      scrub_w = m_scrub_on && !alu_wren_A && !alu_wren_B;
      if (scrub_w) begin
        e_addr_a = AW'(m_idx);
        e_addr_b = AW'(m_idx + BASE_B);
        if (m_idx == DEPTH - 1) begin
          m_scrub_on = 1'b0;
          done_next  = 1'b1;
        end else begin
          m_idx++;
        end
      end
      if (!scrub_w && pend_before) begin
        r = m_pend[0];
        if (r.bank == 1'b0 && !alu_wren_A) begin
          e_addr_a = AW'(r.addr); e_data_a = r.data; void'(m_pend.pop_front());
        end else if (r.bank == 1'b1 && !alu_wren_B) begin
          e_addr_b = AW'(r.addr + BASE_B); e_data_b = r.data; void'(m_pend.pop_front());
        end
      end
      m_done = done_next;
      if (hs) m_pend.push_back('{bank: host_bank, addr: host_addr, data: host_data});
      else if (scrub_start && idle_before && !pend_before) begin
        m_scrub_on = 1'b1;
        m_idx      = 0;
      end
    end
    @(posedge clock);
    #1;
    exp_state = m_scrub_on ? SCRUB : (m_done ? DONE : IDLE);
    check("write_addr_A", 64'(write_addr_A), 64'(e_addr_a));
    check("write_data_A", 64'(write_data_A), 64'(e_data_a));
    check("write_addr_B", 64'(write_addr_B), 64'(e_addr_b));
    check("write_data_B", 64'(write_data_B), 64'(e_data_b));
    check("scrub_busy", 64'(scrub_busy), 64'(m_scrub_on || m_done));
    check("scrub_done", 64'(scrub_done), 64'(m_done));
    check("dbg_state", 64'(dbg_state), 64'(exp_state));
  endtask

  task automatic drive_idle();
    alu_wren_A = 1'b0; alu_wren_B = 1'b0;
    alu_write_addr_A = '0; alu_write_addr_B = '0;
    alu_write_data_A = '0; alu_write_data_B = '0;
    host_valid = 1'b0; host_bank = 1'b0; host_addr = '0; host_data = '0;
    scrub_start = 1'b0;
  endtask

  initial begin
    model_reset();
    drive_idle();
    reset_n = 1'b0;
    step();
    step();
    check("reset_addr_A", 64'(write_addr_A), 64'(NULL_A));
    check("reset_data_B", 64'(write_data_B), 64'(0));
    reset_n = 1'b1;
    step();

    // ALU only
    alu_wren_A = 1'b1; alu_write_addr_A = 12'd5; alu_write_data_A = 36'h123;
    step();
    check("alu_only_addr", 64'(write_addr_A), 64'(5));
    check("alu_only_data", 64'(write_data_A), 64'(36'h123));
    drive_idle();

    // host to bank B, ALU idle
    host_valid = 1'b1; host_bank = 1'b1; host_addr = 10'd3; host_data = 36'hABC;
    step();
    drive_idle();
    step();
    check("host_b_addr", 64'(write_addr_B), 64'(1027));
    check("host_b_data", 64'(write_data_B), 64'(36'hABC));
    step();

    // host to bank A while the ALU writes A for four cycles
    host_valid = 1'b1; host_bank = 1'b0; host_addr = 10'd9; host_data = 36'h55;
    for (int i = 0; i < 4; i++) begin
      alu_wren_A = 1'b1; alu_write_addr_A = AW'(100 + i); alu_write_data_A = WW'(i + 7);
      step();
      host_valid = 1'b0;
    end
    drive_idle();
    step();
    check("host_a_after_alu", 64'(write_addr_A), 64'(9));

    // full scrub, ALU idle
    scrub_start = 1'b1;
    step();
    scrub_start = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) step();

    // scrub with ALU writing bank B on two cycles
    scrub_start = 1'b1;
    step();
    scrub_start = 1'b0;
    for (int i = 0; i < DEPTH + 5; i++) begin
      alu_wren_B = (i == 2 || i == 3);
      alu_write_addr_B = AW'(200 + i); alu_write_data_B = WW'(36'hF00 + i);
      step();
    end
    drive_idle();

    // reset mid-scrub, then a fresh scrub restarts at address 0
    scrub_start = 1'b1;
    step();
    scrub_start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    host_valid = 1'b1; host_bank = 1'b1; host_addr = 10'd17; host_data = 36'h777;
    reset_n = 1'b0;
    step();
    check("mid_scrub_reset_addr", 64'(write_addr_A), 64'(NULL_A));
    reset_n = 1'b1;
    drive_idle();
    scrub_start = 1'b1;
    step();
    scrub_start = 1'b0;
    step();
    check("scrub_restart_addr", 64'(write_addr_A), 64'(0));
    for (int i = 0; i < DEPTH + 2; i++) step();

    // host handshake and scrub_start together: host wins
    host_valid = 1'b1; host_bank = 1'b0; host_addr = 10'd44; host_data = 36'h9;
    scrub_start = 1'b1;
    step();
    drive_idle();
    step();
    step();

    // random phase
    for (int i = 0; i < 600; i++) begin
      reset_n          = ($urandom_range(0, 99) != 0);
      alu_wren_A       = ($urandom_range(0, 1) == 1);
      alu_wren_B       = ($urandom_range(0, 1) == 1);
      alu_write_addr_A = AW'($urandom());
      alu_write_addr_B = AW'($urandom());
      alu_write_data_A = WW'({$urandom(), $urandom()});
      alu_write_data_B = WW'({$urandom(), $urandom()});
      host_valid       = ($urandom_range(0, 2) != 0);
      host_bank        = ($urandom_range(0, 1) == 1);
      host_addr        = MW'($urandom());
      host_data        = WW'({$urandom(), $urandom()});
      scrub_start      = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
